ext_mem_ctrl: RTL

//  Parametrised async-mode controller for the shared board memory bus (cellular RAM + parallel FLASH).

---
 rtl/ext_mem_pkg.sv | 23 ++
 rtl/ext_mem_ctrl_sync2.sv | 21 ++
 rtl/ext_mem_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and encodings for the external memory bus controller.
package ext_mem_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_STS_WAIT,
        ST_TURN
    } state_e;

    localparam logic CS_RAM   = 1'b0;
    localparam logic CS_FLASH = 1'b1;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ext_mem_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous FLASH status line.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/ext_mem_ctrl.sv
// Async-mode controller for the shared cellular RAM / parallel FLASH bus.
// Board outputs are registered from the next-state decode so pins line up with the state.
module ext_mem_ctrl
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int RAM_RD_CYC = 7,
    parameter int RAM_WR_CYC = 7,
    parameter int FL_RD_CYC  = 11,
    parameter int FL_WR_CYC  = 8,
    parameter int TURN_CYC   = 2,
    parameter int FRST_CYC   = 100
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              RW,
    input  logic              CS,
    input  logic [1:0]        BE,
    input  logic [ADDR_W-1:0] ADDR_INT,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              BUSY,
    output logic              READY,
    inout  wire  [DATA_W-1:0] DATA_EXT,
    output logic [ADDR_W-1:0] ADDR_EXT,
    output logic              OE,
    output logic              WE,
    output logic              F_RST,
    output logic              F_CS,
    input  logic              F_STS,
    output logic              R_ADV,
    output logic              R_CS,
    output logic              R_LB,
    output logic              R_UB,
    output logic              R_CLK,
    output logic              R_CRE,
    input  logic              R_WAIT
);

    localparam int MAX_CYC = max2(max2(max2(RAM_RD_CYC, RAM_WR_CYC), max2(FL_RD_CYC, FL_WR_CYC)),
                                  max2(TURN_CYC, FRST_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, strobe_lim;
    logic                rw_q, rw_d, cs_q, cs_d;
    logic [1:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_ext_q, addr_ext_d;
    logic                ack_q, ack_d, busy_q, busy_d, ready_q, ready_d;
    logic                oe_q, oe_d, we_q, we_d, f_rst_q, f_rst_d;
    logic                f_cs_q, f_cs_d, r_cs_q, r_cs_d, r_lb_q, r_lb_d, r_ub_q, r_ub_d;
    logic                drive_q, drive_d;
    logic                sts_sync, in_acc, is_wr;
    logic                unused_ok;

    sync2 u_sts_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (F_STS),
        .q     (sts_sync)
    );

    always_comb begin
        if (cs_q == CS_RAM) strobe_lim = (rw_q == RW_READ) ? CNT_W'(RAM_RD_CYC - 1) : CNT_W'(RAM_WR_CYC - 1);
        else                strobe_lim = (rw_q == RW_READ) ? CNT_W'(FL_RD_CYC - 1)  : CNT_W'(FL_WR_CYC - 1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        rw_d       = rw_q;
        cs_d       = cs_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        addr_ext_d = addr_ext_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_INIT:   if (cnt_q == CNT_W'(FRST_CYC - 1)) state_d = ST_IDLE;
            ST_IDLE: begin
                if (REQ) begin
                    state_d    = ST_SETUP;
                    rw_d       = RW;
                    cs_d       = CS;
                    be_d       = BE;
                    wdata_d    = WDATA;
                    addr_ext_d = ADDR_INT;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: begin
                if (cnt_q == strobe_lim) begin
                    state_d = ST_HOLD;
                    if (rw_q == RW_READ) rdata_d = DATA_EXT;
                end
            end
            ST_HOLD:   state_d = (cs_q == CS_FLASH && rw_q == RW_WRITE) ? ST_STS_WAIT : ST_TURN;
            ST_STS_WAIT: begin
                // Saturate at 1: only "at least two cycles in this state" matters here.
                cnt_d = CNT_W'(1);
                if (cnt_q != '0 && sts_sync) state_d = ST_TURN;
            end
            ST_TURN:   if (cnt_q == CNT_W'(TURN_CYC - 1)) state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
        if (state_d != state_q) cnt_d = '0;

        in_acc  = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD};
        is_wr   = (rw_d == RW_WRITE);
        r_cs_d  = !(in_acc && cs_d == CS_RAM);
        f_cs_d  = !(in_acc && cs_d == CS_FLASH);
        oe_d    = !(state_d == ST_STROBE && !is_wr);
        we_d    = !(state_d == ST_STROBE && is_wr);
        r_lb_d  = !(in_acc && cs_d == CS_RAM && (!is_wr || be_d[0]));
        r_ub_d  = !(in_acc && cs_d == CS_RAM && (!is_wr || be_d[1]));
        drive_d = in_acc && is_wr;
        ack_d   = (state_d == ST_HOLD && !(cs_d == CS_FLASH && is_wr)) ||
                  (state_q == ST_STS_WAIT && state_d == ST_TURN);
        busy_d  = !(state_d inside {ST_INIT, ST_IDLE});
        ready_d = (state_d != ST_INIT);
        f_rst_d = ready_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            rw_q       <= RW_READ;
            cs_q       <= CS_RAM;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_ext_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            f_rst_q    <= 1'b0;
            f_cs_q     <= 1'b1;
            r_cs_q     <= 1'b1;
            r_lb_q     <= 1'b1;
            r_ub_q     <= 1'b1;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            cs_q       <= cs_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_ext_q <= addr_ext_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            f_rst_q    <= f_rst_d;
            f_cs_q     <= f_cs_d;
            r_cs_q     <= r_cs_d;
            r_lb_q     <= r_lb_d;
            r_ub_q     <= r_ub_d;
            drive_q    <= drive_d;
        end
    end

    assign DATA_EXT  = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign RDATA     = rdata_q;
    assign ACK       = ack_q;
    assign BUSY      = busy_q;
    assign READY     = ready_q;
    assign ADDR_EXT  = addr_ext_q;
    assign OE        = oe_q;
    assign WE        = we_q;
    assign F_RST     = f_rst_q;
    assign F_CS      = f_cs_q;
    assign R_CS      = r_cs_q;
    assign R_LB      = r_lb_q;
    assign R_UB      = r_ub_q;
    // Async mode: ADV tied active, no clock, no config-register access, WAIT ignored.
    assign R_ADV     = 1'b0;
    assign R_CLK     = 1'b0;
    assign R_CRE     = 1'b0;
    assign unused_ok = &{1'b1, R_WAIT};

endmodule
